regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2, meaning ALU cycles from alu_start to result valid (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15, meaning maximum cycles spent waiting for op_done (range 1..255).
REQ-003 SHALL have port clk  in  1  single clock; all flops on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid  in  1  instruction offered.
REQ-006 SHALL have port instr_ready  out  1  controller accepts instruction.
REQ-007 SHALL have port instr_op  in  2  00 NOP, 01 ALU (R-type), 10 LOADI, 11 illegal.
REQ-008 SHALL have port instr_regs  in  15  packed {rs1,rs2,rd}.
REQ-009 SHALL have port instr_imm  in  32  immediate for LOADI.
REQ-010 SHALL have port rs_addr_valid  out  1  register-file address latch strobe.
REQ-011 SHALL have port rs1_rs2_rd  out  15  captured {rs1,rs2,rd}.
REQ-012 SHALL have port rs_store  out  1  immediate-store enable.
REQ-013 SHALL have port imme_data  out  32  captured immediate.
REQ-014 SHALL have port rd_wr_en  out  1  ALU write-back enable.
REQ-015 SHALL have port alu_start  out  1  one-cycle ALU launch pulse.
REQ-016 SHALL have port op_done  in  1  register-file completion acknowledge.
REQ-017 SHALL have port retire  out  1  one-cycle pulse per completed instruction.
REQ-018 SHALL have port err  out  1  one-cycle pulse on illegal op or timeout.

Function
REQ-019 SHALL implement FSM states IDLE, LATCH, EXEC, WB, WAIT_DONE; all outputs registered or decoded from state only.
REQ-020 SHALL assert instr_ready only in IDLE; handshake completes when instr_valid && instr_ready on one edge, capturing op/regs/imm.
REQ-021 NOP accepted: retire pulses the next cycle; state stays IDLE.
REQ-022 Illegal op accepted: err pulses the next cycle; state stays IDLE; no register-file strobe.
REQ-023 ALU/LOADI accepted: next state LATCH; rs1_rs2_rd and imme_data hold captured values until the next accept.
REQ-024 LATCH lasts exactly 1 cycle: rs_addr_valid=1, rs_store=1 iff LOADI; next state WAIT_DONE (LOADI) or EXEC (ALU).
REQ-025 EXEC: alu_start=1 in its first cycle only; state remains EXEC for exactly ALU_LAT cycles, then WB.
REQ-026 WB lasts exactly 1 cycle with rd_wr_en=1, rs_addr_valid=0; next state WAIT_DONE.
REQ-027 rs_addr_valid and rd_wr_en SHALL never be high in the same cycle.
REQ-028 WAIT_DONE: op_done=1 -> retire pulses next cycle and state goes IDLE; timeout counter reaching TIMEOUT_CYC without op_done -> err pulses next cycle, state goes IDLE, no retire.
REQ-029 op_done outside WAIT_DONE SHALL be ignored; instr_valid while busy SHALL be ignored (no capture).
REQ-030 Accepted-instruction latency (ALU, immediate ack) = 1 LATCH + ALU_LAT + 1 WB + 1 WAIT_DONE cycles before retire.

Reset
REQ-031 rst_n low SHALL force state IDLE immediately, clearing all counters; instr_ready, rs_addr_valid, rs_store, rd_wr_en, alu_start, retire, err = 0; rs1_rs2_rd, imme_data = 0.
REQ-032 instr_ready SHALL rise on the first posedge after rst_n deasserts; reset mid-operation abandons the instruction with no retire or err.

Configuration
REQ-033 Macro REGFILE_CTRL_B2B_EN defined: in WAIT_DONE with op_done=1, instr_ready=1 and an accepted ALU/LOADI goes directly to LATCH (retire still pulses); undefined: instr_ready only in IDLE, one idle cycle between instructions.

Structure
REQ-034 Package regfile_ctrl_pkg SHALL hold the state enum, the op-code enum, and rs1/rs2/rd field-slice constants.
REQ-035 One sub-module regfile_ctrl_cnt (loadable down-counter with zero flag) SHALL serve both the ALU-latency and the timeout counts.

Verification
REQ-036 LOADI regs={0,0,5}, imm=0xDEADBEEF, op_done one cycle after LATCH -> rs_store=1 with rs_addr_valid=1 for 1 cycle, retire 2 cycles after LATCH.
REQ-037 ALU regs={1,2,3}, ALU_LAT=2 -> alu_start 1 cycle, rd_wr_en exactly 2 cycles later, retire after op_done.
REQ-038 op 11 -> err pulse next cycle, rs_addr_valid never asserted, instr_ready high again next cycle.
REQ-039 LOADI with op_done withheld, TIMEOUT_CYC=4 -> err after 4 WAIT_DONE cycles, no retire, returns IDLE.
REQ-040 rst_n low during EXEC -> all outputs 0 immediately; instr_ready=1 first edge after release; no retire.
REQ-041 Two back-to-back ALU instructions with and without REGFILE_CTRL_B2B_EN -> second LATCH starts 1 cycle earlier when defined.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file controller: FSM states, op-codes and
// the {rs1,rs2,rd} field layout of the packed register-select word.
package regfile_ctrl_pkg;

    localparam int CNT_W   = 8;
    localparam int REG_W   = 5;
    localparam int RD_LSB  = 0;
    localparam int RS2_LSB = 5;
    localparam int RS1_LSB = 10;
    localparam int REGS_W  = 3 * REG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EXEC,
        S_WB,
        S_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOADI = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    function automatic logic [REGS_W-1:0] pack_regs(input logic [REG_W-1:0] rs1,
                                                    input logic [REG_W-1:0] rs2,
                                                    input logic [REG_W-1:0] rd);
        logic [REGS_W-1:0] r;
        r = '0;
        r[RS1_LSB +: REG_W] = rs1;
        r[RS2_LSB +: REG_W] = rs2;
        r[RD_LSB  +: REG_W] = rd;
        return r;
    endfunction

    // ALU and LOADI are the ops that walk through the register-file sequence.
    function automatic logic is_seq_op(input op_t op);
        return (op == OP_ALU) || (op == OP_LOADI);
    endfunction

endpackage

// File: rtl/regfile_ctrl_cnt.sv
// Loadable down-counter with zero flag; shared by ALU-latency and timeout.
// Latency: load/decrement take effect on the next edge. Backpressure: none.
module regfile_ctrl_cnt
    import regfile_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file sequencing controller: accepts one instruction, drives latch/ALU/write-back, waits for op_done.
// Latency: ALU = 1 LATCH + ALU_LAT EXEC + 1 WB + WAIT_DONE cycles; LOADI skips EXEC/WB. Optional REGFILE_CTRL_B2B_EN.
// Backpressure: instr_ready low while busy; with REGFILE_CTRL_B2B_EN a new ALU/LOADI may be taken in the op_done cycle.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int ALU_LAT     = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [REGS_W-1:0] instr_regs,
    input  logic [31:0]       instr_imm,
    output logic              rs_addr_valid,
    output logic [REGS_W-1:0] rs1_rs2_rd,
    output logic              rs_store,
    output logic [31:0]       imme_data,
    output logic              rd_wr_en,
    output logic              alu_start,
    input  logic              op_done,
    output logic              retire,
    output logic              err
);

    localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    op_t              op_q;
    op_t              op_in;
    logic             ready_q;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign op_in  = op_t'(instr_op);
    assign accept = instr_valid && instr_ready;

`ifdef REGFILE_CTRL_B2B_EN
    logic b2b_ok;
    assign b2b_ok      = (state == S_WAIT_DONE) && op_done && is_seq_op(op_in);
    assign instr_ready = ready_q | b2b_ok;
`else
    assign instr_ready = ready_q;
`endif

    assign rs_addr_valid = (state == S_LATCH);
    assign rs_store      = (state == S_LATCH) && (op_q == OP_LOADI);
    assign rd_wr_en      = (state == S_WB);

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            S_LATCH: begin
                cnt_load = 1'b1;
                cnt_val  = (op_q == OP_ALU) ? ALU_LD : TO_LD;
            end
            S_WB: begin
                cnt_load = 1'b1;
                cnt_val  = TO_LD;
            end
            S_EXEC, S_WAIT_DONE: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    regfile_ctrl_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_NOP;
            ready_q    <= 1'b0;
            retire     <= 1'b0;
            err        <= 1'b0;
            alu_start  <= 1'b0;
            rs1_rs2_rd <= '0;
            imme_data  <= '0;
        end else begin
            retire    <= 1'b0;
            err       <= 1'b0;
            alu_start <= 1'b0;
            ready_q   <= 1'b0;
            if (accept) begin
                op_q       <= op_in;
                rs1_rs2_rd <= instr_regs;
                imme_data  <= instr_imm;
            end
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        case (op_in)
                            OP_NOP: retire <= 1'b1;
                            OP_ILL: err    <= 1'b1;
                            default: begin
                                state   <= S_LATCH;
                                ready_q <= 1'b0;
                            end
                        endcase
                    end
                end
                S_LATCH: begin
                    if (op_q == OP_ALU) begin
                        state     <= S_EXEC;
                        alu_start <= 1'b1;
                    end else begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_EXEC: begin
                    if (cnt_zero) state <= S_WB;
                end
                S_WB: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (op_done) begin
                        retire <= 1'b1;
                        // accept can only be high here when the B2B path is built in
                        if (accept) begin
                            state <= S_LATCH;
                        end else begin
                            state   <= S_IDLE;
                            ready_q <= 1'b1;
                        end
                    end else if (cnt_zero) begin
                        err     <= 1'b1;
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl (ALU_LAT=2, TIMEOUT_CYC=4); expectations follow REGFILE_CTRL_B2B_EN.
module tb_regfile_ctrl;
    import regfile_ctrl_pkg::*;

`ifdef REGFILE_CTRL_B2B_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic [14:0] instr_regs;
    logic [31:0] instr_imm;
    logic        rs_addr_valid;
    logic [14:0] rs1_rs2_rd;
    logic        rs_store;
    logic [31:0] imme_data;
    logic        rd_wr_en;
    logic        alu_start;
    logic        op_done;
    logic        retire;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_ctrl #(.ALU_LAT(2), .TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_regs    (instr_regs),
        .instr_imm     (instr_imm),
        .rs_addr_valid (rs_addr_valid),
        .rs1_rs2_rd    (rs1_rs2_rd),
        .rs_store      (rs_store),
        .imme_data     (imme_data),
        .rd_wr_en      (rd_wr_en),
        .alu_start     (alu_start),
        .op_done       (op_done),
        .retire        (retire),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        // {instr_ready, rs_addr_valid, rs_store, rd_wr_en, alu_start, retire, err}
        chk(tag, {25'd0, instr_ready, rs_addr_valid, rs_store, rd_wr_en, alu_start, retire, err},
            {25'd0, exp});
    endtask

    task automatic offer(input logic [1:0] op, input logic [14:0] regs, input logic [31:0] imm);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_regs  = regs;
        instr_imm   = imm;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 2'b00;
        instr_regs  = '0;
        instr_imm   = '0;
        op_done     = 1'b0;

        // Reset state
        tick; tick;
        chk_ctl("reset_ctl", 7'b0000000);
        chk("reset_regs", {17'd0, rs1_rs2_rd}, 32'd0);
        chk("reset_imm", imme_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk_ctl("release_pre_edge", 7'b0000000);
        tick;
        chk_ctl("ready_after_release", 7'b1000000);

        // LOADI {0,0,5}, op_done in the first WAIT_DONE cycle
        offer(2'b10, pack_regs(5'd0, 5'd0, 5'd5), 32'hDEADBEEF);
        tick;
        instr_valid = 1'b0;
        chk_ctl("loadi_latch", 7'b0110000);
        chk("loadi_regs", {17'd0, rs1_rs2_rd}, 32'd5);
        chk("loadi_imm", imme_data, 32'hDEADBEEF);
        tick;
        chk_ctl("loadi_wait", 7'b0000000);
        op_done = 1'b1;
        tick;
        op_done = 1'b0;
        chk_ctl("loadi_retire", 7'b1000010);
        chk("loadi_imm_hold", imme_data, 32'hDEADBEEF);

        // ALU {1,2,3}; op_done held high early must be ignored until WAIT_DONE
        offer(2'b01, pack_regs(5'd1, 5'd2, 5'd3), 32'd0);
        op_done = 1'b1;
        tick;
        instr_valid = 1'b0;
        chk_ctl("alu_latch", 7'b0100000);
        chk("alu_regs", {17'd0, rs1_rs2_rd}, 32'd1091);
        tick;
        chk_ctl("alu_exec1", 7'b0000100);
        tick;
        chk_ctl("alu_exec2", 7'b0000000);
        tick;
        op_done = 1'b0;
        chk_ctl("alu_wb", 7'b0001000);
        tick;
        chk_ctl("alu_wait", 7'b0000000);
        op_done = 1'b1;
        tick;
        op_done = 1'b0;
        chk_ctl("alu_retire", 7'b1000010);

        // Illegal op, then NOP
        offer(2'b11, pack_regs(5'd9, 5'd9, 5'd9), 32'd0);
        tick;
        instr_valid = 1'b0;
        chk_ctl("illegal_err", 7'b1000001);
        offer(2'b00, '0, 32'd0);
        tick;
        instr_valid = 1'b0;
        chk_ctl("nop_retire", 7'b1000010);
        tick;
        chk_ctl("idle_quiet", 7'b1000000);

        // LOADI timeout; a busy-time offer must not be captured
        offer(2'b10, pack_regs(5'd0, 5'd0, 5'd7), 32'h12345678);
        tick;
        instr_valid = 1'b0;
        chk_ctl("to_latch", 7'b0110000);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) offer(2'b01, pack_regs(5'd3, 5'd3, 5'd3), 32'hFFFFFFFF);
            tick;
            instr_valid = 1'b0;
            chk_ctl($sformatf("to_wait%0d", i), 7'b0000000);
        end
        chk("busy_no_capture", {17'd0, rs1_rs2_rd}, 32'd7);
        tick;
        chk_ctl("to_err", 7'b1000001);

        // Reset asserted during EXEC
        offer(2'b01, pack_regs(5'd4, 5'd5, 5'd6), 32'hA5A5A5A5);
        tick;
        instr_valid = 1'b0;
        tick;
        chk_ctl("rst_exec_pre", 7'b0000100);
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_mid_ctl", 7'b0000000);
        chk("rst_mid_regs", {17'd0, rs1_rs2_rd}, 32'd0);
        chk("rst_mid_imm", imme_data, 32'd0);
        tick;
        rst_n   = 1'b1;
        op_done = 1'b1;
        tick;
        chk_ctl("rst_release_ready", 7'b1000000);
        tick;
        chk_ctl("rst_no_retire", 7'b1000000);
        op_done = 1'b0;

        // Two back-to-back ALU instructions
        offer(2'b01, pack_regs(5'd1, 5'd1, 5'd1), 32'd0);
        tick;
        instr_valid = 1'b0;
        chk_ctl("b2b_latch1", 7'b0100000);
        tick; tick; tick;
        chk_ctl("b2b_wb1", 7'b0001000);
        tick;
        offer(2'b01, pack_regs(5'd2, 5'd2, 5'd2), 32'd0);
        op_done = 1'b1;
        #1;
        chk("b2b_ready_in_wait", {31'd0, instr_ready}, {31'd0, B2B});
        tick;
        op_done = 1'b0;
        chk("b2b_retire1", {31'd0, retire}, 32'd1);
        chk("b2b_latch2_early", {31'd0, rs_addr_valid}, {31'd0, B2B});
        tick;
        instr_valid = 1'b0;
        chk("b2b_latch2_late", {31'd0, rs_addr_valid}, {31'd0, ~B2B});
        chk("b2b_regs2", {17'd0, rs1_rs2_rd}, {17'd0, pack_regs(5'd2, 5'd2, 5'd2)});
        chk("b2b_alu_start2", {31'd0, alu_start}, {31'd0, B2B});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
